// File: rtl/spi_cfg_pkg.sv
// Shared types and constants for the SPI configuration master.
// Latency: none (declarations only).
// Backpressure: n/a.
// Contents: frame/field widths and the master FSM state encoding.
package spi_cfg_pkg;

  localparam int FRAME_BITS = 48;
  localparam int ADDR_BITS  = 16;
  localparam int DATA_BITS  = 32;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_RDY = 2'd1,
    SHIFT    = 2'd2,
    GAP      = 2'd3
  } state_t;

endpackage

// File: rtl/spi_sck_gen.sv
// SCK phase timer: splits each bit into a low phase then a high phase of HALF_PERIOD clocks.
// Latency: strobes are combinational from the phase counter; counter restarts the cycle i_en rises.
// Backpressure: none; i_en low holds the timer at the start of a low phase.
// Ports: i_clk/i_rst_n clock and async active-low reset; i_en run enable;
//        o_sck_rise (last low-phase cycle), o_sck_fall (last high-phase cycle),
//        o_bit_start (first low-phase cycle).
module spi_sck_gen #(
  parameter int HALF_PERIOD = 4
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_en,
  output logic o_sck_rise,
  output logic o_sck_fall,
  output logic o_bit_start
);

  localparam int PW = $clog2(HALF_PERIOD + 1);
  localparam logic [PW-1:0] LAST = PW'(HALF_PERIOD - 1);

  logic [PW-1:0] r_phase;
  logic          r_high;
  logic          w_last;

  assign w_last = (r_phase == LAST);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_phase <= '0;
      r_high  <= 1'b0;
    end else if (!i_en) begin
      r_phase <= '0;
      r_high  <= 1'b0;
    end else if (w_last) begin
      r_phase <= '0;
      r_high  <= ~r_high;
    end else begin
      r_phase <= r_phase + PW'(1);
    end
  end

  assign o_sck_rise  = i_en & ~r_high & w_last;
  assign o_sck_fall  = i_en &  r_high & w_last;
  assign o_bit_start = i_en & ~r_high & (r_phase == '0);

endmodule

// File: rtl/spi_cfg_master.sv
// SPI master: sends {addr,wdata} as a 48-bit MSB-first frame, returns the 32 data-phase MISO bits.
// Latency: RSP_VALID 96*HALF_PERIOD+1 cycles after accept; ready again GAP_CYCLES+1 cycles later.
// Backpressure: CMD_READY low from the cycle after accept until the inter-frame gap ends.
// Ports: CLK, RST_N (async active-low); CMD_VALID/CMD_READY/CMD_ADDR/CMD_WDATA command;
//        RSP_VALID/RSP_RDATA response; BUSY; SCK/MOSI/MISO serial; SPI_RDY chip ready.
// Option: define SPI_CFG_MASTER_RDY_WAIT_EN to hold each frame in WAIT_RDY until SPI_RDY
//         (2-flop synchronised) is high; otherwise SPI_RDY is ignored.
module spi_cfg_master
  import spi_cfg_pkg::*;
#(
  parameter int HALF_PERIOD = 4,
  parameter int GAP_CYCLES  = 8
) (
  input  logic                 CLK,
  input  logic                 RST_N,
  input  logic                 CMD_VALID,
  output logic                 CMD_READY,
  input  logic [ADDR_BITS-1:0] CMD_ADDR,
  input  logic [DATA_BITS-1:0] CMD_WDATA,
  output logic                 RSP_VALID,
  output logic [DATA_BITS-1:0] RSP_RDATA,
  output logic                 BUSY,
  output logic                 SCK,
  output logic                 MOSI,
  input  logic                 MISO,
  input  logic                 SPI_RDY
);

  localparam logic [5:0] BIT_FIRST = 6'(FRAME_BITS - 1);
  localparam logic [7:0] GAP_LAST  = 8'(GAP_CYCLES);

  state_t                  r_state, w_next;
  logic                    r_rdy, r_sck, r_vld, r_last;
  logic [5:0]              r_bit;
  logic [7:0]              r_gap;
  logic [FRAME_BITS-1:0]   r_tx;
  logic [DATA_BITS-2:0]    r_rx;
  logic [DATA_BITS-1:0]    r_rdata;
  logic                    w_accept, w_shift, w_rise, w_fall, w_bit_start, w_done;

  assign w_accept = CMD_VALID & r_rdy;
  assign w_shift  = (r_state == SHIFT);
  // r_last is settled at the start of bit 0, so the final falling edge closes the frame.
  assign w_done   = w_fall & r_last;

`ifdef SPI_CFG_MASTER_RDY_WAIT_EN
  logic r_rdy_s1, r_rdy_s2;
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_rdy_s1 <= 1'b0;
      r_rdy_s2 <= 1'b0;
    end else begin
      r_rdy_s1 <= SPI_RDY;
      r_rdy_s2 <= r_rdy_s1;
    end
  end
`else
  logic w_unused_rdy;
  assign w_unused_rdy = SPI_RDY;
`endif

  spi_sck_gen #(.HALF_PERIOD(HALF_PERIOD)) u_sck_gen (
    .i_clk       (CLK),
    .i_rst_n     (RST_N),
    .i_en        (w_shift),
    .o_sck_rise  (w_rise),
    .o_sck_fall  (w_fall),
    .o_bit_start (w_bit_start)
  );

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
`ifdef SPI_CFG_MASTER_RDY_WAIT_EN
          w_next = WAIT_RDY;
`else
          w_next = SHIFT;
`endif
        end
      end
      WAIT_RDY: begin
`ifdef SPI_CFG_MASTER_RDY_WAIT_EN
        if (r_rdy_s2) w_next = SHIFT;
`else
        w_next = IDLE;
`endif
      end
      SHIFT:   if (w_done) w_next = GAP;
      GAP:     if (r_gap == GAP_LAST) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_rdy   <= 1'b0;
      r_sck   <= 1'b0;
      r_vld   <= 1'b0;
      r_last  <= 1'b0;
      r_bit   <= '0;
      r_gap   <= '0;
      r_tx    <= '0;
      r_rx    <= '0;
      r_rdata <= '0;
    end else begin
      r_rdy <= (w_next == IDLE);
      r_vld <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_tx   <= {CMD_ADDR, CMD_WDATA};
            r_bit  <= BIT_FIRST;
            r_last <= 1'b0;
          end
        end
        SHIFT: begin
          if (w_bit_start) r_last <= (r_bit == 6'd0);
          if (w_rise) r_sck <= 1'b1;
          if (w_fall) begin
            r_sck <= 1'b0;
            r_tx  <= {r_tx[FRAME_BITS-2:0], 1'b0};
            // Only the newest 32 samples survive, i.e. the data phase.
            r_rx  <= {r_rx[DATA_BITS-3:0], MISO};
            if (r_last) begin
              r_rdata <= {r_rx, MISO};
              r_vld   <= 1'b1;
              r_gap   <= '0;
            end else begin
              r_bit <= r_bit - 6'd1;
            end
          end
        end
        GAP:     r_gap <= r_gap + 8'd1;
        default: ;
      endcase
    end
  end

  assign CMD_READY = r_rdy;
  assign RSP_VALID = r_vld;
  assign RSP_RDATA = r_rdata;
  assign BUSY      = (r_state != IDLE);
  assign SCK       = r_sck;
  // Combinational from state so MOSI drops with the async reset and outside SHIFT.
  assign MOSI      = w_shift & r_tx[FRAME_BITS-1];

endmodule

// File: tb/tb_spi_cfg_master.sv
module tb_spi_cfg_master;

  localparam int HP  = 4;
  localparam int GAP = 8;
`ifdef SPI_CFG_MASTER_RDY_WAIT_EN
  localparam int W = 1;
`else
  localparam int W = 0;
`endif

  logic        CLK = 1'b0;
  logic        RST_N;
  logic        CMD_VALID, CMD_READY, RSP_VALID, BUSY, SCK, MOSI, MISO, SPI_RDY;
  logic [15:0] CMD_ADDR;
  logic [31:0] CMD_WDATA, RSP_RDATA;

  logic        h_valid, h_ready, h_rvld, h_busy, h_sck, h_mosi, h_miso, h_spi_rdy;
  logic [15:0] h_addr;
  logic [31:0] h_wdata, h_rdata;

  always #5 CLK = ~CLK;

  spi_cfg_master #(.HALF_PERIOD(HP), .GAP_CYCLES(GAP)) dut (
    .CLK(CLK), .RST_N(RST_N), .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY),
    .CMD_ADDR(CMD_ADDR), .CMD_WDATA(CMD_WDATA), .RSP_VALID(RSP_VALID), .RSP_RDATA(RSP_RDATA),
    .BUSY(BUSY), .SCK(SCK), .MOSI(MOSI), .MISO(MISO), .SPI_RDY(SPI_RDY)
  );

  spi_cfg_master #(.HALF_PERIOD(1), .GAP_CYCLES(0)) dut1 (
    .CLK(CLK), .RST_N(RST_N), .CMD_VALID(h_valid), .CMD_READY(h_ready),
    .CMD_ADDR(h_addr), .CMD_WDATA(h_wdata), .RSP_VALID(h_rvld), .RSP_RDATA(h_rdata),
    .BUSY(h_busy), .SCK(h_sck), .MOSI(h_mosi), .MISO(h_miso), .SPI_RDY(h_spi_rdy)
  );

  typedef struct {
    logic [15:0] addr;
    logic [31:0] wdata;
    logic [47:0] miso;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs[4];
  int   total = 0;
  int   bad   = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic wait_ready(input string tag);
    int n;
    n = 0;
    @(negedge CLK);
    while (!CMD_READY && n < 1000) begin
      @(negedge CLK);
      n++;
    end
    check({tag, " ready before accept"}, CMD_READY, 1);
  endtask

  task automatic run_frame(input string tag, input vec_t v);
    int c, bi, rises, sck_err, vld_cyc, vld_cnt, rdy_cyc, gap_err, busy_err;
    logic [47:0] stream;
    logic [31:0] rdata_v;
    logic        prev_sck;
    rises = 0; sck_err = 0; vld_cyc = -1; vld_cnt = 0; rdy_cyc = -1;
    gap_err = 0; busy_err = 0; stream = '0; rdata_v = '0; prev_sck = 1'b0;
    wait_ready(tag);
    CMD_VALID = 1'b1; CMD_ADDR = v.addr; CMD_WDATA = v.wdata;
    bi = 47; MISO = v.miso[47];
    @(posedge CLK); #1;
    CMD_VALID = 1'b0; CMD_ADDR = ~v.addr; CMD_WDATA = ~v.wdata;
    for (c = 1; c <= 1000 && rdy_cyc < 0; c++) begin
      @(negedge CLK);
      if (SCK && !prev_sck) begin
        stream = {stream[46:0], MOSI};
        if (c != 1 + W + HP + 2 * HP * rises) sck_err++;
        rises++;
      end
      if (!SCK && prev_sck) begin
        if (c != 1 + W + 2 * HP * rises) sck_err++;
        bi--;
        if (bi >= 0) MISO = v.miso[bi];
        else         MISO = 1'b0;
      end
      if (RSP_VALID) begin
        vld_cnt++;
        if (vld_cyc < 0) begin
          vld_cyc = c;
          rdata_v = RSP_RDATA;
        end
      end
      if (vld_cyc >= 0 && (SCK || MOSI)) gap_err++;
      if (CMD_READY) rdy_cyc = c;
      else if (!BUSY) busy_err++;
      prev_sck = SCK;
    end
    check({tag, " mosi stream"}, stream, {v.addr, v.wdata});
    check({tag, " sck pulses"}, rises, 48);
    check({tag, " sck edge timing errors"}, sck_err, 0);
    check({tag, " rsp_valid cycle"}, vld_cyc, 96 * HP + 1 + W);
    check({tag, " rsp_valid width"}, vld_cnt, 1);
    check({tag, " rsp_rdata"}, rdata_v, v.exp_rdata);
    check({tag, " rsp_rdata hold"}, RSP_RDATA, v.exp_rdata);
    check({tag, " ready reassert cycle"}, rdy_cyc, 96 * HP + GAP + 2 + W);
    check({tag, " gap sck/mosi high"}, gap_err, 0);
    check({tag, " busy low mid-frame"}, busy_err, 0);
  endtask

  initial begin
    int c, v1, v2, acc2, gap_sck, rises, vld, err, rdy;
    logic        prev;
    logic [31:0] r1;
    logic [47:0] stream;

    vecs[0] = '{16'h1234, 32'hDEADBEEF, 48'h0000_0000_0000, 32'h0000_0000};
    vecs[1] = '{16'h8001, 32'h0000_0000, 48'hFFFF_A5A5_0F0F, 32'hA5A5_0F0F};
    vecs[2] = '{16'hFFFF, 32'hFFFF_FFFF, 48'h0000_FFFF_FFFF, 32'hFFFF_FFFF};
    vecs[3] = '{16'h0000, 32'h0000_0001, 48'hFFFF_8000_0001, 32'h8000_0001};

    RST_N = 1'b0; CMD_VALID = 1'b0; CMD_ADDR = '0; CMD_WDATA = '0; MISO = 1'b0; SPI_RDY = 1'b1;
    h_valid = 1'b0; h_addr = '0; h_wdata = '0; h_miso = 1'b0; h_spi_rdy = 1'b1;
    repeat (3) @(negedge CLK);
    check("reset SCK", SCK, 0);
    check("reset MOSI", MOSI, 0);
    check("reset CMD_READY", CMD_READY, 0);
    check("reset RSP_VALID", RSP_VALID, 0);
    check("reset RSP_RDATA", RSP_RDATA, 0);
    check("reset BUSY", BUSY, 0);
    RST_N = 1'b1;
    repeat (3) @(negedge CLK);

    for (int i = 0; i < 4; i++) run_frame($sformatf("vec%0d", i), vecs[i]);

    // Back-to-back: CMD_VALID stays high across two commands.
    wait_ready("b2b");
    CMD_VALID = 1'b1; CMD_ADDR = 16'h0101; CMD_WDATA = 32'h1111_1111; MISO = 1'b0;
    @(posedge CLK); #1;
    CMD_ADDR = 16'h0202; CMD_WDATA = 32'h2222_2222;
    v1 = -1; acc2 = -1; gap_sck = 0; r1 = '1;
    for (c = 1; c <= 1000 && acc2 < 0; c++) begin
      @(negedge CLK);
      if (RSP_VALID && v1 < 0) begin
        v1 = c; r1 = RSP_RDATA; MISO = 1'b1;
      end
      if (v1 >= 0 && SCK) gap_sck++;
      if (CMD_READY) acc2 = c;
    end
    check("b2b first rdata", r1, 32'h0);
    check("b2b second accept distance", acc2 - v1, GAP + 1);
    check("b2b sck in gap", gap_sck, 0);
    @(posedge CLK); #1;
    CMD_VALID = 1'b0;
    v2 = -1;
    for (c = 1; c <= 1000 && v2 < 0; c++) begin
      @(negedge CLK);
      if (RSP_VALID) v2 = c;
    end
    check("b2b second rsp cycle", v2, 96 * HP + 1 + W);
    check("b2b second rdata", RSP_RDATA, 32'hFFFF_FFFF);
    MISO = 1'b0;

    // Reset while bit 20 is on the wire.
    wait_ready("rst");
    CMD_VALID = 1'b1; CMD_ADDR = 16'h5A5A; CMD_WDATA = 32'h1234_5678;
    @(posedge CLK); #1;
    CMD_VALID = 1'b0;
    rises = 0; prev = 1'b0; c = 0;
    while (rises < 28 && c < 1000) begin
      @(negedge CLK);
      c++;
      if (SCK && !prev) rises++;
      prev = SCK;
    end
    check("rst reached bit 20", rises, 28);
    check("rst SCK high before reset", SCK, 1);
    #2 RST_N = 1'b0;
    #1;
    check("rst SCK async low", SCK, 0);
    check("rst MOSI async low", MOSI, 0);
    check("rst BUSY async low", BUSY, 0);
    vld = 0;
    repeat (4) begin
      @(negedge CLK);
      if (RSP_VALID) vld++;
    end
    check("rst no rsp_valid", vld, 0);
    check("rst rdata cleared", RSP_RDATA, 0);
    RST_N = 1'b1;
    repeat (3) @(negedge CLK);
    run_frame("post-reset", vecs[0]);

    // HALF_PERIOD=1, GAP_CYCLES=0 instance.
    c = 0;
    @(negedge CLK);
    while (!h_ready && c < 100) begin
      @(negedge CLK);
      c++;
    end
    h_valid = 1'b1; h_addr = 16'hC3C3; h_wdata = 32'h3C3C_3C3C; h_miso = 1'b1;
    @(posedge CLK); #1;
    h_valid = 1'b0;
    err = 0; v1 = -1; rdy = -1; stream = '0; prev = 1'b0;
    for (c = 1; c <= 300 && rdy < 0; c++) begin
      @(negedge CLK);
      if (c >= 1 + W && c <= 96 + W && (h_sck !== ((c - W) % 2 == 0))) err++;
      if (h_sck && !prev) stream = {stream[46:0], h_mosi};
      if (h_rvld && v1 < 0) v1 = c;
      if (h_ready) rdy = c;
      prev = h_sck;
    end
    check("hp1 sck toggle errors", err, 0);
    check("hp1 mosi stream", stream, 48'hC3C3_3C3C_3C3C);
    check("hp1 rsp cycle", v1, 97 + W);
    check("hp1 rdata", h_rdata, 32'hFFFF_FFFF);
    check("hp1 ready cycle", rdy, 98 + W);

`ifdef SPI_CFG_MASTER_RDY_WAIT_EN
    SPI_RDY = 1'b0;
    repeat (4) @(negedge CLK);
    wait_ready("rdy");
    CMD_VALID = 1'b1; CMD_ADDR = 16'h1234; CMD_WDATA = 32'hDEAD_BEEF; MISO = 1'b0;
    @(posedge CLK); #1;
    CMD_VALID = 1'b0;
    err = 0; v1 = -1; v2 = -1; prev = 1'b0; stream = '0;
    for (c = 1; c <= 1000 && v2 < 0; c++) begin
      @(negedge CLK);
      if (c == 50) SPI_RDY = 1'b1;
      if (SCK && !prev) begin
        if (v1 < 0) v1 = c;
        stream = {stream[46:0], MOSI};
      end
      if (RSP_VALID) v2 = c;
      prev = SCK;
    end
    check("rdy first sck rise", v1, 50 + 3 + HP);
    check("rdy mosi stream", stream, 48'h1234_DEAD_BEEF);
    check("rdy rsp cycle", v2, 50 + 3 + 96 * HP);
    check("rdy rdata", RSP_RDATA, 32'h0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/spi_cfg_master.md
Name: spi_cfg_master

Overview:
- Host-side SPI master that drives the SCK/MOSI/MISO interface of the chip's SPI slave configuration port.
- Converts single-word commands (16-bit address + 32-bit data) into 48-bit serial frames, MSB first.
- Returns the 32 bits shifted in on MISO during the data phase.
- Used in the simulation/FPGA harness to program parameters and SRAMs, and to read back state.

Parameters:
- HALF_PERIOD, 4, CLK cycles per SCK phase (low or high); legal range 1..255.
- GAP_CYCLES, 8, idle CLK cycles enforced between frames, SCK low; legal range 0..255.

Ports:
- CLK  in  1  system clock.
- RST_N  in  1  asynchronous reset, active-low.
- CMD_VALID  in  1  command offered.
- CMD_READY  out  1  command can be accepted.
- CMD_ADDR  in  16  address field, sent first.
- CMD_WDATA  in  32  data field, sent after the address.
- RSP_VALID  out  1  one-cycle pulse when a frame completes.
- RSP_RDATA  out  32  MISO bits captured during the data phase.
- BUSY  out  1  high from command accept through the end of GAP.
- SCK  out  1  SPI clock, idle low.
- MOSI  out  1  serial data out.
- MISO  in  1  serial data in.
- SPI_RDY  in  1  chip ready flag; only used with the optional feature.

Behaviour:
- Reset values (async on RST_N low): SCK=0, MOSI=0, CMD_READY=0 while RST_N low, RSP_VALID=0, RSP_RDATA=0, BUSY=0, state IDLE, all counters 0.
- FSM states: IDLE, SHIFT, GAP.
- IDLE:
  - CMD_READY=1.
  - Handshake on CMD_VALID&CMD_READY latches {CMD_ADDR,CMD_WDATA} into a 48-bit shift register, sets bit counter=47, then SHIFT.
  - CMD_READY drops the cycle after accept.
- SHIFT:
  - Each bit occupies 2*HALF_PERIOD CLK cycles: low phase then high phase.
  - MOSI is updated to the current MSB on the first cycle of the low phase, so it is stable for HALF_PERIOD cycles before SCK rises.
  - SCK rises after HALF_PERIOD cycles and falls after a further HALF_PERIOD cycles.
  - On the CLK edge that drives SCK high→low, MISO is shifted into the receive register (LSB in) and the transmit register shifts left.
  - Only samples taken for bits 31..0 (the data phase) are retained in RSP_RDATA; address-phase samples are discarded.
  - After the 48th falling edge: RSP_RDATA updates, RSP_VALID pulses for exactly one cycle, MOSI returns to 0, then GAP.
- GAP:
  - Counts GAP_CYCLES with SCK=0, then IDLE.
  - If GAP_CYCLES=0, goes to IDLE on the next cycle.
- Latency: accept at cycle 0; RSP_VALID at cycle 96*HALF_PERIOD+1; CMD_READY reasserts at cycle 96*HALF_PERIOD+GAP_CYCLES+2.
- CMD_VALID while not ready: ignored, no queueing; inputs are sampled only at the handshake cycle.
- The command fields may change after accept without affecting the frame in flight.
- RSP_RDATA holds its value until the next frame completes.
- Reset mid-frame: frame aborted, no RSP_VALID; SCK goes low immediately (async).
- HALF_PERIOD=1: SCK toggles every CLK; behaviour otherwise identical.
- Phase counter width = clog2(HALF_PERIOD+1); bit counter 6 bits.

Optional Feature:
- Macro SPI_CFG_MASTER_RDY_WAIT_EN.
- Defined:
  - Adds state WAIT_RDY, entered from IDLE on accept.
  - Stays in WAIT_RDY, SCK low, until SPI_RDY is sampled high (2-flop synchronised), then enters SHIFT.
  - Latency grows by the synchronizer delay (2 cycles) plus the wait time.
  - Reset in WAIT_RDY returns to IDLE with no response.
- Undefined: SPI_RDY is unused and SHIFT starts the cycle after accept.

Decomposition:
- Shared package spi_cfg_pkg:
  - FRAME_BITS=48, ADDR_BITS=16, DATA_BITS=32.
  - FSM state enum {IDLE, WAIT_RDY, SHIFT, GAP}.
- One sub-module, spi_sck_gen: phase counter producing the sck_rise, sck_fall and bit_start strobes from HALF_PERIOD.
- The shift registers and FSM stay in spi_cfg_master.

Test Plan:
- Write 0x1234/0xDEADBEEF, HALF_PERIOD=4, MISO=0 -> MOSI bit-stream 0x1234DEADBEEF MSB first, 48 SCK pulses each 4 high/4 low, RSP_VALID at cycle 385, RSP_RDATA=0.
- Read: slave model drives 0xA5A5_0F0F on MISO (updated on SCK fall) in the data phase -> RSP_RDATA=0xA5A50F0F; address-phase MISO=1 ignored.
- Back-to-back: CMD_VALID held high with two commands, GAP_CYCLES=8 -> second accept exactly 8+1 cycles after the first RSP_VALID; SCK low throughout the gap.
- RST_N low at bit 20 of a frame -> SCK=0 and MOSI=0 immediately, no RSP_VALID; a new command after reset produces a clean 48-bit frame.
- HALF_PERIOD=1, GAP_CYCLES=0 -> SCK toggles every cycle; RSP_VALID at cycle 97.
- With SPI_CFG_MASTER_RDY_WAIT_EN, SPI_RDY low for 50 cycles after accept -> no SCK edge until 2 cycles after SPI_RDY rises; frame then matches the first scenario.
